// File: rtl/rca_pipe_arbiter.sv
// rtl/rca_pipe_arbiter.sv - round-robin arbiter sharing one pipelined ripple-carry adder
// Grants one requester per cycle and tags each in-flight op so results return with their requester ID.
module rca_pipe_arbiter #(
  parameter int Nbits = 8,
  parameter int Nreq  = 4,
  parameter int LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_en,
  input  logic [Nreq-1:0]              req_valid,
  output logic [Nreq-1:0]              req_ready,
  input  logic [Nreq*Nbits-1:0]        req_a,
  input  logic [Nreq*Nbits-1:0]        req_b,
  input  logic [Nreq-1:0]              req_cin,
  output logic [Nbits-1:0]             add_a,
  output logic [Nbits-1:0]             add_b,
  output logic                         add_cin,
  input  logic [Nbits-1:0]             add_sum,
  input  logic                         add_cout,
  output logic                         rsp_valid,
  output logic [$clog2(Nreq)-1:0]      rsp_id,
  output logic [Nbits-1:0]             rsp_sum,
  output logic                         rsp_cout,
  output logic [$clog2(LAT+1)-1:0]     inflight,
  output logic                         busy
);

  localparam int IDW = $clog2(Nreq);
  localparam int CW  = $clog2(LAT+1);

  logic [IDW-1:0] r_ptr;
  logic [LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [LAT];
  logic [CW-1:0]  r_inflight;

  logic           w_grant_any;
  logic [IDW-1:0] w_grant_idx;
  logic [IDW:0]   w_cand;

  // Cyclic search from r_ptr; candidate index wraps without a modulo so any Nreq works.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (!rst && issue_en) begin
      for (int k = 0; k < Nreq; k++) begin
        w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_cand >= (IDW+1)'(Nreq)) w_cand = w_cand - (IDW+1)'(Nreq);
        if (!w_grant_any && req_valid[w_cand[IDW-1:0]]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    for (int i = 0; i < Nreq; i++) begin
      if (w_grant_any && (w_grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[i*Nbits +: Nbits];
        add_b        = req_b[i*Nbits +: Nbits];
        add_cin      = req_cin[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_tag_v    <= '0;
      r_inflight <= '0;
      for (int s = 0; s < LAT; s++) r_tag_id[s] <= '0;
    end else begin
      if (w_grant_any)
        r_ptr <= (w_grant_idx == IDW'(Nreq-1)) ? '0 : w_grant_idx + 1'b1;
      r_tag_v[0]  <= w_grant_any;
      r_tag_id[0] <= w_grant_idx;
      for (int s = 1; s < LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      case ({w_grant_any, r_tag_v[LAT-1]})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Adder result is passed straight through, masked when no tagged op retires.
  assign rsp_valid = r_tag_v[LAT-1];
  assign rsp_id    = rsp_valid ? r_tag_id[LAT-1] : '0;
  assign rsp_sum   = rsp_valid ? add_sum : '0;
  assign rsp_cout  = rsp_valid & add_cout;
  assign inflight  = r_inflight;
  assign busy      = (r_inflight != '0);

endmodule

// File: tb/tb_rca_pipe_arbiter.sv
// tb/tb_rca_pipe_arbiter.sv - scoreboard bench for rca_pipe_arbiter with a 2-stage adder model
module tb_rca_pipe_arbiter;

  logic        clk;
  logic        rst;
  logic        issue_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_cin;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic [1:0]  inflight;
  logic        busy;

  logic [7:0]  ta [4];
  logic [7:0]  tb [4];
  logic [8:0]  p0 = '0;
  logic [8:0]  p1 = '0;

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [8:0] res;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 0;
  bit   done   = 0;

  rca_pipe_arbiter #(.Nbits(8), .Nreq(4), .LAT(2)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .inflight(inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-register adder: inputs sampled at the transfer edge, sum visible LAT cycles after issue.
  always @(posedge clk) begin
    p0 <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    p1 <= p0;
  end
  assign add_sum  = p1[7:0];
  assign add_cout = p1[8];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = ta[i];
      req_b[i*8 +: 8] = tb[i];
    end
  end

  always @(negedge clk) begin
    if (mon_en && !done) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_missing cyc=%0d: no response, required id=%0d res=%h", cyc, q[0].id, q[0].res);
        void'(q.pop_front());
      end
      n_vec++;
      if (rsp_valid) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          n_err++;
          $display("FAIL rsp_unexpected cyc=%0d: got id=%0d res=%h, none required", cyc, rsp_id, {rsp_cout, rsp_sum});
        end else begin
          if (rsp_id !== q[0].id || {rsp_cout, rsp_sum} !== q[0].res) begin
            n_err++;
            $display("FAIL rsp_data cyc=%0d: got id=%0d res=%h, required id=%0d res=%h",
                     cyc, rsp_id, {rsp_cout, rsp_sum}, q[0].id, q[0].res);
          end
          void'(q.pop_front());
        end
      end else if ({rsp_id, rsp_cout, rsp_sum} !== 11'd0) begin
        n_err++;
        $display("FAIL rsp_mask cyc=%0d: got id=%0d res=%h, required zeros", cyc, rsp_id, {rsp_cout, rsp_sum});
      end
    end
  end

  // One cycle: check grant and occupancy, register expected result, advance past the edge.
  task automatic tick(input logic [3:0] er, input logic [8:0] res, input bit push, input int ei);
    exp_t e;
    @(negedge clk);
    n_vec++;
    if (req_ready !== er) begin
      n_err++;
      $display("FAIL req_ready cyc=%0d: got %b, required %b", cyc, req_ready, er);
    end
    if (ei >= 0) begin
      n_vec++;
      if (inflight !== 2'(ei)) begin
        n_err++;
        $display("FAIL inflight cyc=%0d: got %0d, required %0d", cyc, inflight, ei);
      end
      n_vec++;
      if (busy !== (ei != 0)) begin
        n_err++;
        $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, ei != 0);
      end
    end
    if (push && er != 4'd0) begin
      e.cyc = cyc + 2;
      e.res = res;
      e.id  = 2'd0;
      for (int i = 0; i < 4; i++) if (er[i]) e.id = 2'(i);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    ta[i] = a;
    tb[i] = b;
    req_cin[i] = c;
  endtask

  initial begin
    rst = 1'b1; issue_en = 1'b1; req_valid = 4'hF; req_cin = 4'h0;
    for (int i = 0; i < 4; i++) set_op(i, 8'h00, 8'h00, 1'b0);

    // reset: no grants while rst is high, counters clear
    tick(4'b0000, 9'h000, 0, -1);
    mon_en = 1'b1;
    tick(4'b0000, 9'h000, 0, 0);
    rst = 1'b0; req_valid = 4'h0;
    tick(4'b0000, 9'h000, 0, 0);

    // single op from requester 1
    set_op(1, 8'h01, 8'h01, 1'b0); req_valid = 4'b0010;
    tick(4'b0010, 9'h002, 1, 0);
    req_valid = 4'h0;
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 0);

    // back-to-back carry cases on requester 0
    req_valid = 4'b0001;
    set_op(0, 8'hFF, 8'h01, 1'b1); tick(4'b0001, 9'h101, 1, 0);
    set_op(0, 8'hFF, 8'hFF, 1'b1); tick(4'b0001, 9'h1FF, 1, 1);
    set_op(0, 8'hCC, 8'hAA, 1'b0); tick(4'b0001, 9'h176, 1, 2);
    set_op(0, 8'hFF, 8'hFF, 1'b0); tick(4'b0001, 9'h1FE, 1, 2);
    req_valid = 4'h0;
    tick(4'b0000, 9'h000, 0, 2);
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 0);

    // all requesters valid from reset: 0,1,2,3,0,1
    rst = 1'b1;
    tick(4'b0000, 9'h000, 0, 0);
    rst = 1'b0;
    set_op(0, 8'h10, 8'h01, 1'b0);
    set_op(1, 8'h80, 8'h80, 1'b1);
    set_op(2, 8'h7F, 8'h01, 1'b0);
    set_op(3, 8'hF0, 8'h20, 1'b1);
    req_valid = 4'hF;
    tick(4'b0001, 9'h011, 1, 0);
    tick(4'b0010, 9'h101, 1, 1);
    tick(4'b0100, 9'h080, 1, 2);
    tick(4'b1000, 9'h111, 1, 2);
    tick(4'b0001, 9'h011, 1, 2);
    tick(4'b0010, 9'h101, 1, 2);
    req_valid = 4'h0;
    tick(4'b0000, 9'h000, 0, 2);
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 0);

    // wrap: grant 2, then 3 before 0
    req_valid = 4'b0100;
    tick(4'b0100, 9'h080, 1, 0);
    req_valid = 4'b1001;
    tick(4'b1000, 9'h111, 1, 1);
    tick(4'b0001, 9'h011, 1, 2);
    req_valid = 4'h0;
    tick(4'b0000, 9'h000, 0, 2);
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 0);

    // reset with an op in flight: result dropped, search restarts at 0
    req_valid = 4'b0010;
    tick(4'b0010, 9'h101, 0, 0);
    req_valid = 4'h0; rst = 1'b1;
    tick(4'b0000, 9'h000, 0, 1);
    rst = 1'b0;
    tick(4'b0000, 9'h000, 0, 0);
    tick(4'b0000, 9'h000, 0, 0);
    req_valid = 4'b1010;
    tick(4'b0010, 9'h101, 1, 0);
    req_valid = 4'h0;
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 0);

    // issue_en gating, then drop it with two ops in flight
    issue_en = 1'b0; req_valid = 4'hF;
    tick(4'b0000, 9'h000, 0, 0);
    tick(4'b0000, 9'h000, 0, 0);
    tick(4'b0000, 9'h000, 0, 0);
    issue_en = 1'b1;
    tick(4'b0100, 9'h080, 1, 0);
    tick(4'b1000, 9'h111, 1, 1);
    issue_en = 1'b0;
    tick(4'b0000, 9'h000, 0, 2);
    tick(4'b0000, 9'h000, 0, 1);
    tick(4'b0000, 9'h000, 0, 0);

    @(negedge clk);
    done = 1'b1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rca_pipe_arbiter.md
Name: rca_pipe_arbiter

Overview:
Round-robin arbiter and scheduler that shares one pipelined ripple-carry adder (fixed latency, no stall input) between Nreq requesters. Each cycle it grants at most one requester and drives the adder inputs from that requester. It tracks the requester ID of every in-flight operation in a tag pipeline matched to the adder latency. It returns each result tagged with the originating requester ID.

Parameters:
Nbits, 8, operand/sum width
Nreq, 4, number of requesters (any value >= 2, power of 2 not required)
LAT, 2, adder latency in clock edges from input sample to valid sum (equals the adder's Nstages)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
issue_en  in  1  when low, no grants are issued
req_valid  in  Nreq  per-requester operation pending
req_ready  out  Nreq  one-hot grant; transfer = valid & ready
req_a  in  Nreq*Nbits  operand A; requester i at [i*Nbits +: Nbits]
req_b  in  Nreq*Nbits  operand B, same packing
req_cin  in  Nreq  carry-in per requester
add_a  out  Nbits  to adder a
add_b  out  Nbits  to adder b
add_cin  out  1  to adder cin
add_sum  in  Nbits  from adder sum
add_cout  in  1  from adder cout
rsp_valid  out  1  result valid this cycle
rsp_id  out  clog2(Nreq)  requester index of result
rsp_sum  out  Nbits  result sum
rsp_cout  out  1  result carry-out
inflight  out  clog2(LAT+1)  operations currently in the adder
busy  out  1  inflight != 0

Behaviour:
- Arbitration is combinational.
  - Grant goes to the lowest index i, searching cyclically starting at ptr, with req_valid[i]=1.
  - No grant if issue_en=0 or rst=1.
  - At most one grant per cycle; req_ready is one-hot or zero.
- Pointer update: on a grant to i, ptr <= (i+1) mod Nreq at the clock edge. With no grant, ptr holds. Reset value of ptr is 0.
- Adder drive (combinational):
  - With a grant: add_a/add_b/add_cin = the granted requester's operands.
  - With no grant: all three driven to 0.
  - The adder samples them at the same edge that completes the transfer.
- Tag pipeline: LAT stages of {v, id}.
  - Stage 0 loads {grant_any, grant_idx}.
  - Each stage shifts every cycle, unconditionally; there is no stall.
- Response timing: for a transfer at edge k, rsp_valid=1 in the cycle following edge k+LAT-1, i.e. exactly LAT cycles after the request cycle.
  - rsp_id comes from the last tag stage.
  - rsp_sum = add_sum and rsp_cout = add_cout, passed through combinationally.
  - When rsp_valid=0, rsp_id/rsp_sum/rsp_cout are 0 (masked).
- Throughput is one operation per cycle; back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Consumers have no backpressure: a result is presented for exactly one cycle and must be taken.
- inflight counts valid tags.
  - +1 on transfer, -1 on retire.
  - Simultaneous transfer and retire leaves it unchanged.
  - Maximum value is LAT; it never overflows.
- Arithmetic is the adder's: {cout, sum} = a + b + cin, modulo 2^(Nbits+1). The block never alters data.
- Reset (synchronous, edge with rst=1):
  - ptr=0, all tag valid bits=0, inflight=0.
  - rsp_valid=0 and busy=0 from the cycle after the reset edge.
  - req_ready=0 while rst=1.
  - Operations in flight at reset are dropped: the adder still produces sums, but no rsp_valid is asserted for them.
- issue_en low mid-stream: the block stops granting, in-flight operations still retire, and busy falls after at most LAT cycles.
- A requester deasserting req_valid without being granted is legal and has no side effect.

Test Plan:
1. Nbits=8, Nreq=4, LAT=2. Requester 1 only, a=0x01 b=0x01 cin=0 at cycle 0 -> req_ready=4'b0010 in cycle 0; rsp_valid=1 in cycle 2 with rsp_id=1, rsp_sum=0x02, rsp_cout=0; busy=1 in cycles 1-2, 0 in cycle 3.
2. Carry cases, requester 0: 0xFF+0x01+1 -> sum=0x01, cout=1; 0xFF+0xFF+1 -> sum=0xFF, cout=1; 0xCC+0xAA+0 -> sum=0x76, cout=1; 0xFF+0xFF+0 -> sum=0xFE, cout=1. All issued back-to-back, each response exactly 2 cycles after its issue, in order.
3. All four requesters valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence identical, delayed 2 cycles; inflight=2 in steady state.
4. Wrap: after a grant to requester 2 (ptr=3), requesters 0 and 3 valid -> requester 3 granted first, then 0 on the next cycle.
5. Reset mid-operation: transfer at cycle 0, rst=1 in cycle 1 -> rsp_valid stays 0 in cycles 2-3, inflight=0, busy=0, next grant search starts at requester 0.
6. issue_en=0 with all requesters valid -> req_ready=0 every cycle, no rsp_valid; deassert issue_en with 2 operations in flight -> both retire, then busy=0.
